unified_mem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the pipeline's instruction-fetch

---
 rtl/unified_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/unified_mem_arbiter.sv
// Unified memory arbiter: one single-ported memory shared by the fetch (I) and data (D) ports.
// Optional macro ARB_FAIRNESS_EN bounds how long a waiting fetch can be starved by data grants.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    state_t              state_reg, state_next;
    logic                owner_reg, owner_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [DATA_W-1:0]   i_rdata_reg, i_rdata_next;
    logic [DATA_W-1:0]   d_rdata_reg, d_rdata_next;
    logic                i_starved;
    logic                grant_d;

`ifdef ARB_FAIRNESS_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_reg, starve_cnt_next;

    assign i_starved = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

    // Counts back-to-back D wins over a waiting fetch; any other grant resets it.
    always_comb begin
        starve_cnt_next = starve_cnt_reg;
        if (state_reg == ST_IDLE && (d_req || i_req)) begin
            if (grant_d && i_req)
                starve_cnt_next = starve_cnt_reg + CNT_W'(1);
            else
                starve_cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            starve_cnt_reg <= '0;
        else
            starve_cnt_reg <= starve_cnt_next;
    end
`else
    assign i_starved = 1'b0;
`endif

    // Data wins ties (older instruction) unless the fetch has been starved too long.
    assign grant_d = d_req && !(i_req && i_starved);

    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        we_next      = we_reg;
        addr_next    = addr_reg;
        wdata_next   = wdata_reg;
        i_rdata_next = i_rdata_reg;
        d_rdata_next = d_rdata_reg;
        case (state_reg)
            ST_IDLE: begin
                if (grant_d) begin
                    owner_next = OWNER_D;
                    we_next    = d_we;
                    addr_next  = d_addr;
                    wdata_next = d_wdata;
                    state_next = ST_ACCESS;
                end else if (i_req) begin
                    owner_next = OWNER_I;
                    we_next    = 1'b0;
                    addr_next  = i_addr;
                    wdata_next = '0;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem_ready) begin
                    if (owner_reg == OWNER_I)
                        i_rdata_next = mem_rdata;
                    else if (!we_reg)
                        d_rdata_next = mem_rdata;
                    state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            owner_reg   <= OWNER_I;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            i_rdata_reg <= '0;
            d_rdata_reg <= '0;
        end else begin
            state_reg   <= state_next;
            owner_reg   <= owner_next;
            we_reg      <= we_next;
            addr_reg    <= addr_next;
            wdata_reg   <= wdata_next;
            i_rdata_reg <= i_rdata_next;
            d_rdata_reg <= d_rdata_next;
        end
    end

    assign mem_valid = (state_reg == ST_ACCESS);
    assign mem_we    = mem_valid && we_reg;
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign i_ready   = (state_reg == ST_RESP) && (owner_reg == OWNER_I);
    assign d_ready   = (state_reg == ST_RESP) && (owner_reg == OWNER_D);
    assign i_rdata   = i_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed vector table plus multi-cycle sequences
// (tie priority, fairness/starvation order, reset during an access).
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ready;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waitc;
        logic [31:0] mdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!mem_valid && n < 20) begin
            tick();
            n++;
        end
        if (!mem_valid)
            check("mem_valid_timeout", {31'd0, mem_valid}, 32'd1);
    endtask

    // Wait for the grant, check the memory request, complete it after waitc extra cycles,
    // and check the ready pulse that follows.
    task automatic serve(input logic exp_d, input logic exp_we, input logic [31:0] exp_addr,
                         input logic [31:0] exp_wdata, input int waitc, input logic [31:0] mdata);
        wait_valid();
        check("mem_addr", mem_addr, exp_addr);
        check("mem_we", {31'd0, mem_we}, {31'd0, exp_we});
        if (exp_we)
            check("mem_wdata", mem_wdata, exp_wdata);
        for (int k = 0; k < waitc; k++) begin
            tick();
            check("mem_valid_hold", {31'd0, mem_valid}, 32'd1);
            check("mem_addr_hold", mem_addr, exp_addr);
        end
        mem_ready = 1'b1;
        mem_rdata = mdata;
        tick();
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        check("i_ready_pulse", {31'd0, i_ready}, {31'd0, ~exp_d});
        check("d_ready_pulse", {31'd0, d_ready}, {31'd0, exp_d});
        check("mem_valid_resp", {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b0, 32'h10,  32'h0,        1, 32'h00500093, 32'h00500093};
        vecs[1] = '{1'b1, 1'b1, 32'h40,  32'h12345678, 2, 32'hFFFF0000, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 32'h100, 32'h0,        0, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[3] = '{1'b0, 1'b0, 32'h24,  32'h0,        3, 32'h11112222, 32'h11112222};
        vecs[4] = '{1'b1, 1'b1, 32'h44,  32'hA5A5A5A5, 0, 32'h5A5A5A5A, 32'hCAFEF00D};
        vecs[5] = '{1'b1, 1'b0, 32'h8,   32'h0,        1, 32'h0BADF00D, 32'h0BADF00D};

        reset = 1'b1; i_req = 1'b1; i_addr = 32'h10;
        d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        mem_ready = 1'b0; mem_rdata = 32'h0;

        // Reset held two cycles with a pending fetch
        for (int k = 0; k < 2; k++) begin
            tick();
            check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
            check("rst_i_ready", {31'd0, i_ready}, 32'd0);
            check("rst_busy", {31'd0, busy}, 32'd0);
        end
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_i_rdata", i_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        reset = 1'b0; i_req = 1'b0;
        tick();
        $display("txn reset done");

        // Simultaneous fetch and load: D first, then I
        i_req = 1'b1; i_addr = 32'h20;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100;
        serve(1'b1, 1'b0, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        check("tie_d_rdata", d_rdata, 32'hDEADBEEF);
        d_req = 1'b0;
        tick();
        check("tie_i_wait", {31'd0, i_ready}, 32'd0);
        serve(1'b0, 1'b0, 32'h20, 32'h0, 0, 32'h00000013);
        check("tie_i_rdata", i_rdata, 32'h00000013);
        i_req = 1'b0;
        tick();
        check("tie_idle", {31'd0, busy}, 32'd0);
        $display("txn tie: D then I served");

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].is_d) begin
                d_req = 1'b1; d_we = vecs[v].we; d_addr = vecs[v].addr; d_wdata = vecs[v].wdata;
            end else begin
                i_req = 1'b1; i_addr = vecs[v].addr;
            end
            serve(vecs[v].is_d, vecs[v].we, vecs[v].addr, vecs[v].wdata,
                  vecs[v].waitc, vecs[v].mdata);
            if (vecs[v].is_d)
                check("vec_d_rdata", d_rdata, vecs[v].exp_rdata);
            else
                check("vec_i_rdata", i_rdata, vecs[v].exp_rdata);
            i_req = 1'b0; d_req = 1'b0;
            tick();
            check("vec_pulse_width", {31'd0, i_ready | d_ready}, 32'd0);
            check("vec_busy", {31'd0, busy}, 32'd0);
            $display("txn vec %0d %s we=%0d addr=%h i_rdata=%h d_rdata=%h", v,
                     vecs[v].is_d ? "D" : "I", vecs[v].we, vecs[v].addr, i_rdata, d_rdata);
        end

        // Both requests held: grant order depends on the fairness option
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        for (int g = 0; g < 8; g++) begin
            logic exp_d;
`ifdef ARB_FAIRNESS_EN
            exp_d = ((g % 4) != 3);
`else
            exp_d = 1'b1;
`endif
            wait_valid();
            check("grant_order", {31'd0, mem_addr == 32'h300}, {31'd0, exp_d});
            $display("txn grant %0d to %s", g, (mem_addr == 32'h300) ? "D" : "I");
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
        tick();
        check("starve_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of an access abandons it
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        wait_valid();
        reset = 1'b1;
        tick();
        check("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_d_ready", {31'd0, d_ready}, 32'd0);
        reset = 1'b0; d_req = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'h77777777;
        tick();
        mem_ready = 1'b0; mem_rdata = 32'h0;
        check("late_ready_busy", {31'd0, busy}, 32'd0);
        check("late_ready_d_ready", {31'd0, d_ready}, 32'd0);
        check("late_ready_d_rdata", d_rdata, 32'h0);
        tick();
        check("late_ready_no_pulse", {31'd0, d_ready | i_ready}, 32'd0);
        $display("txn reset mid-access");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
